// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results immediately and waits on the memory
// read port for loads, extracting and extending the addressed byte/halfword/word.
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rd,
    input  logic        i_rd_wr_en,
    input  logic        i_is_load,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_alu_result,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [4:0]  rd,
    output logic [31:0] rd_wr_data,
    output logic        rd_wr_en,
    output logic        o_retire,
    output logic        o_load_err
);

    localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic [4:0] ld_rd_p0;
    logic       ld_wr_en_p0;
    logic [2:0] ld_funct3_p0;
    logic [1:0] ld_addr_lo_p0;

    logic        capture;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        retire_next;
    logic        err_next;

    // Illegal size encodings and accesses that straddle their natural alignment.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] a);
        logic fault;
        case (f3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = a[0];
            F3_LW:         fault = (a != 2'b00);
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   res = {{24{b[7]}}, b};
            F3_LBU:  res = {24'd0, b};
            F3_LH:   res = {{16{h[15]}}, h};
            F3_LHU:  res = {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign o_ready = (state == IDLE);

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        capture     = 1'b0;
        wb_en       = 1'b0;
        wb_rd       = '0;
        wb_data     = '0;
        retire_next = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                // mem_rd_valid is deliberately not looked at here.
                if (i_valid) begin
                    if (!i_is_load) begin
                        retire_next = 1'b1;
                        wb_en       = i_rd_wr_en && (i_rd != 5'd0);
                        wb_rd       = i_rd;
                        wb_data     = i_alu_result;
                    end else if (load_fault(i_funct3, i_addr_lo)) begin
                        err_next = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        cnt_next   = '0;
                        state_next = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rd_valid) begin
                    retire_next = 1'b1;
                    wb_en       = ld_wr_en_p0 && (ld_rd_p0 != 5'd0);
                    wb_rd       = ld_rd_p0;
                    wb_data     = load_extract(ld_funct3_p0, ld_addr_lo_p0, mem_rd_data);
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // This cycle is the LOAD_TIMEOUT-th spent waiting.
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Stage p0: load descriptor held while waiting for memory
    always_ff @(posedge clk) begin
        if (capture) begin
            ld_rd_p0      <= i_rd;
            ld_wr_en_p0   <= i_rd_wr_en;
            ld_funct3_p0  <= i_funct3;
            ld_addr_lo_p0 <= i_addr_lo;
        end
    end

    // Stage p1: registered writeback port and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rd         <= '0;
            rd_wr_data <= '0;
            rd_wr_en   <= 1'b0;
            o_retire   <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            rd_wr_en   <= wb_en;
            o_retire   <= retire_next;
            o_load_err <= err_next;
            if (wb_en) begin
                rd         <= wb_rd;
                rd_wr_data <= wb_data;
            end
        end
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter LOAD_TIMEOUT SHALL default to 15 and set the maximum cycles spent waiting for load data.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 i_valid  input  1  upstream result valid.
REQ-006 o_ready  output  1  stage can accept a result.
REQ-007 i_rd  input  5  destination register index.
REQ-008 i_rd_wr_en  input  1  instruction writes rd.
REQ-009 i_is_load  input  1  result comes from a memory load.
REQ-010 i_funct3  input  3  load size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 i_addr_lo  input  2  load address bits [1:0].
REQ-012 i_alu_result  input  32  non-load result.
REQ-013 mem_rd_valid  input  1  load data valid strobe.
REQ-014 mem_rd_data  input  32  aligned load word.
REQ-015 rd  output  5  register file write index.
REQ-016 rd_wr_data  output  32  register file write data.
REQ-017 rd_wr_en  output  1  register file write strobe.
REQ-018 o_retire  output  1  one-cycle pulse per completed instruction.
REQ-019 o_load_err  output  1  one-cycle pulse on misaligned, illegal or timed-out load.

Function
REQ-020 The FSM SHALL have states IDLE and WAIT_LOAD; o_ready SHALL be 1 in IDLE and 0 in WAIT_LOAD.
REQ-021 A transfer SHALL occur on a rising edge where i_valid and o_ready are both 1; all i_* fields SHALL be captured at that edge.
REQ-022 Non-load transfer: the block SHALL stay in IDLE and drive rd=i_rd, rd_wr_data=i_alu_result, rd_wr_en=i_rd_wr_en and o_retire=1 for exactly the following cycle.
REQ-023 Back-to-back non-load transfers SHALL produce one write per cycle with no bubble.
REQ-024 Load transfer with legal funct3 and alignment SHALL move the FSM to WAIT_LOAD and clear the timeout counter.
REQ-025 A load SHALL be misaligned when LH/LHU has addr_lo[0]=1 or LW has addr_lo!=00; funct3 011, 110 and 111 SHALL be illegal.
REQ-026 A misaligned or illegal load SHALL pulse o_load_err in the cycle after transfer, produce no write and no retire, and leave the FSM in IDLE.
REQ-027 In WAIT_LOAD, when mem_rd_valid=1 the block SHALL extract and extend the data, drive the write fields and pulse o_retire in the next cycle, then return to IDLE.
REQ-028 Extraction: LB/LBU SHALL use byte addr_lo; LH/LHU SHALL use halfword addr_lo[1]; LW SHALL use the whole word; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend.
REQ-029 In WAIT_LOAD the timeout counter SHALL increment each cycle without mem_rd_valid.
REQ-030 Timeout: when the counter reaches LOAD_TIMEOUT, the block SHALL pulse o_load_err, produce no write and return to IDLE.
REQ-031 mem_rd_valid SHALL be ignored in IDLE, including in the cycle a load transfers.
REQ-032 rd==0 SHALL force rd_wr_en=0 while o_retire still pulses.
REQ-033 rd_wr_en, o_retire and o_load_err SHALL be registered and SHALL be 0 in every cycle that has no completion event.
REQ-034 rd and rd_wr_data SHALL hold their last value when rd_wr_en=0.

Reset
REQ-035 While rst=0: FSM SHALL be IDLE, counter 0, rd=0, rd_wr_data=0, rd_wr_en=0, o_retire=0, o_load_err=0, and o_ready SHALL be 1.
REQ-036 Reset asserted during WAIT_LOAD SHALL discard the pending load with no write or error pulse after release.
REQ-037 A transfer SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-038 Non-load rd=5, alu=0xDEADBEEF, wr_en=1 -> next cycle rd=5, rd_wr_data=0xDEADBEEF, rd_wr_en=1, o_retire=1; three back-to-back transfers -> three consecutive writes.
REQ-039 LB addr_lo=11 with mem data 0x80FF_0000 delivered 3 cycles later -> rd_wr_data=0xFFFFFF80; same stimulus as LBU -> 0x00000080; LHU addr_lo=10 -> 0x000080FF.
REQ-040 LW addr_lo=01 -> o_load_err pulse one cycle later, rd_wr_en=0, o_ready stays 1.
REQ-041 LW legal with mem_rd_valid never asserted -> o_load_err after LOAD_TIMEOUT cycles in WAIT_LOAD, no write, back in IDLE with o_ready=1.
REQ-042 Non-load with rd=0 and alu=0x12345678 -> rd_wr_en=0, o_retire=1.
REQ-043 Reset pulse 2 cycles into WAIT_LOAD, then mem_rd_valid=1 -> all outputs 0, no write, o_ready=1.
